// File: rtl/qmem_dma_master_if.sv
// Qmem master/slave bus bundle: one initiator request channel with
// same-cycle (or stalled) acknowledge and next-cycle read data.
interface qmem_dma_master_if #(
    parameter int QAW = 32,
    parameter int QDW = 32,
    parameter int QSW = QDW / 8
);
    logic [QAW-1:0] m_adr;
    logic           m_cs;
    logic           m_we;
    logic [QSW-1:0] m_sel;
    logic [QDW-1:0] m_dat_w;
    logic [QDW-1:0] m_dat_r;
    logic           m_ack;
    logic           m_err;

    modport master (
        output m_adr, m_cs, m_we, m_sel, m_dat_w,
        input  m_dat_r, m_ack, m_err
    );

    modport slave (
        input  m_adr, m_cs, m_we, m_sel, m_dat_w,
        output m_dat_r, m_ack, m_err
    );
endinterface

// File: rtl/qmem_dma_master.sv
// Single-channel qmem block-copy / block-fill engine. One word per bus
// request; copy alternates read and write, fill streams writes back to back.
module qmem_dma_master #(
    parameter int QAW = 32,
    parameter int QDW = 32,
    parameter int QSW = QDW / 8,
    parameter int LW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            mode,
    input  logic [QAW-1:0]  src_adr,
    input  logic [QAW-1:0]  dst_adr,
    input  logic [LW-1:0]   len,
    input  logic [QDW-1:0]  pattern,
    output logic            busy,
    output logic            done,
    output logic            error,
    qmem_dma_master_if.master bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        RDAT = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t         state_reg;
    state_t         state_next;
    logic [QAW-1:0] src_reg;
    logic [QAW-1:0] dst_reg;
    logic [LW-1:0]  cnt_reg;
    logic           mode_reg;
    logic [QDW-1:0] pat_reg;
    logic [QDW-1:0] buf_reg;
    logic           error_reg;

    logic [QAW-1:0] adr_out;
    logic           cs_out;
    logic           we_out;
    logic [QDW-1:0] dat_out;

    // A request is finished in any cycle the slave acks our chip select.
    logic req_ack;
    assign req_ack = cs_out & bus.m_ack;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode; stalls in RD/WR until the slave acknowledges.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (len == '0)
                        state_next = DONE;
                    else if (mode)
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD: begin
                if (req_ack)
                    state_next = bus.m_err ? DONE : RDAT;
            end
            RDAT: state_next = WR;
            WR: begin
                if (req_ack) begin
                    if (bus.m_err || cnt_reg == LW'(1))
                        state_next = DONE;
                    else if (!mode_reg)
                        state_next = RD;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Transfer parameters, word counter, read buffer and sticky error.
    // On an erroring ack the address/count registers keep the failing word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_reg   <= '0;
            dst_reg   <= '0;
            cnt_reg   <= '0;
            mode_reg  <= 1'b0;
            pat_reg   <= '0;
            buf_reg   <= '0;
            error_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        // Low address bits are forced to zero so the engine
                        // always issues word-aligned requests.
                        src_reg   <= src_adr & ~QAW'(3);
                        dst_reg   <= dst_adr & ~QAW'(3);
                        cnt_reg   <= len;
                        mode_reg  <= mode;
                        pat_reg   <= pattern;
                        error_reg <= 1'b0;
                    end
                end
                RD: begin
                    if (req_ack && bus.m_err)
                        error_reg <= 1'b1;
                end
                RDAT: buf_reg <= bus.m_dat_r;
                WR: begin
                    if (req_ack) begin
                        if (bus.m_err) begin
                            error_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg - LW'(1);
                            src_reg <= src_reg + QAW'(4);
                            dst_reg <= dst_reg + QAW'(4);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus and status outputs decoded purely from the current state, so an
    // asynchronous reset drops any in-flight request immediately.
    always_comb begin
        adr_out = '0;
        cs_out  = 1'b0;
        we_out  = 1'b0;
        dat_out = '0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_reg)
            IDLE: busy = 1'b0;
            RD: begin
                cs_out  = 1'b1;
                adr_out = src_reg;
            end
            WR: begin
                cs_out  = 1'b1;
                we_out  = 1'b1;
                adr_out = dst_reg;
                dat_out = mode_reg ? pat_reg : buf_reg;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign bus.m_adr   = adr_out;
    assign bus.m_cs    = cs_out;
    assign bus.m_we    = we_out;
    assign bus.m_dat_w = dat_out;
    assign bus.m_sel   = {QSW{1'b1}};
    assign error       = error_reg;

endmodule
